// File: rtl/t5_led_pkg.sv
// Shared state encoding and parameter defaults for the T5 LED input conditioner.
package t5_led_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_PEND   = 2'd2
    } led_state_e;

    localparam int unsigned DEB_CYC_DEF  = 16;
    localparam int unsigned ACT_HOLD_DEF = 3277;
    localparam int unsigned ACT_W_DEF    = 12;
    // Debounce counter width covers the full legal DEB_CYC range (2..255).
    localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/t5_led_cond_ch.sv
// One LED channel: 3-flop synchroniser, startup-qualify/debounce FSM and
// activity stretcher.
module t5_led_cond_ch
    import t5_led_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned ACT_HOLD = ACT_HOLD_DEF,
    parameter int unsigned ACT_W    = ACT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic act,
    output logic valid
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [ACT_W-1:0] ACT_LOAD = ACT_W'(ACT_HOLD);

    logic             r1, r2, r3;
    led_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stable_nxt, valid_nxt, act_load;
    logic [ACT_W-1:0] act_cnt, act_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1      <= 1'b0;
            r2      <= 1'b0;
            r3      <= 1'b0;
            state   <= ST_INIT;
            cnt     <= '0;
            stable  <= 1'b0;
            valid   <= 1'b0;
            act_cnt <= '0;
            act     <= 1'b0;
        end else begin
            r1      <= raw;
            r2      <= r1;
            r3      <= r2;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stable  <= stable_nxt;
            valid   <= valid_nxt;
            act_cnt <= act_cnt_nxt;
            // Flag registered from the next count so it tracks act_cnt != 0 exactly.
            act     <= (act_cnt_nxt != '0);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        valid_nxt  = valid;
        act_load   = 1'b0;

        case (state)
            ST_INIT: begin
                if (r2 != r3) begin
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    stable_nxt = r2;
                    valid_nxt  = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = ST_STABLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (r2 != stable) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_PEND;
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_PEND: begin
                if (r2 == stable) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STABLE;
                end else if (cnt == DEB_LAST) begin
                    stable_nxt = r2;
                    cnt_nxt    = '0;
                    act_load   = 1'b1;
                    state_nxt  = ST_STABLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_comb begin
        act_cnt_nxt = act_cnt;
        if (act_load) begin
            act_cnt_nxt = ACT_LOAD;
        end else if (act_cnt != '0) begin
            act_cnt_nxt = act_cnt - ACT_W'(1);
        end
    end

endmodule

// File: rtl/t5_led_cond.sv
// T5 LED input conditioner: NUM_CH independent channel conditioners plus the
// all-channels-valid reduction.
module t5_led_cond
    import t5_led_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned ACT_HOLD = ACT_HOLD_DEF,
    parameter int unsigned ACT_W    = ACT_W_DEF
) (
    input  logic              i_clk_32k,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_led_raw,
    output logic [NUM_CH-1:0] o_led_stable,
    output logic [NUM_CH-1:0] o_led_act,
    output logic [NUM_CH-1:0] o_led_valid,
    output logic              o_all_valid
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        t5_led_cond_ch #(
            .DEB_CYC (DEB_CYC),
            .ACT_HOLD(ACT_HOLD),
            .ACT_W   (ACT_W)
        ) u_ch (
            .clk   (i_clk_32k),
            .rst_n (i_rst_n),
            .raw   (i_led_raw[g]),
            .stable(o_led_stable[g]),
            .act   (o_led_act[g]),
            .valid (o_led_valid[g])
        );
    end

    assign o_all_valid = &o_led_valid;

endmodule

// File: tb/tb_t5_led_cond.sv
// Scoreboard bench for t5_led_cond: expectations are queued per cycle when
// stimulus is driven and compared on the falling edge after that posedge.
module tb_t5_led_cond;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw_m = 4'b0101;
    logic [3:0] raw_r = 4'b0000;
    logic [3:0] st_m, act_m, vld_m, st_r, act_r, vld_r, st_z, act_z, vld_z;
    logic       allv_m, allv_r, allv_z;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        int         dut;
        logic [3:0] st;
        logic [3:0] act;
        logic [3:0] vld;
        string      tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        it;
    logic [12:0] got, want;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    t5_led_cond u_dut_m (
        .i_clk_32k(clk), .i_rst_n(rst_n), .i_led_raw(raw_m),
        .o_led_stable(st_m), .o_led_act(act_m), .o_led_valid(vld_m), .o_all_valid(allv_m)
    );

    t5_led_cond #(.ACT_HOLD(100)) u_dut_r (
        .i_clk_32k(clk), .i_rst_n(rst_n), .i_led_raw(raw_r),
        .o_led_stable(st_r), .o_led_act(act_r), .o_led_valid(vld_r), .o_all_valid(allv_r)
    );

    t5_led_cond #(.ACT_HOLD(0)) u_dut_z (
        .i_clk_32k(clk), .i_rst_n(rst_n), .i_led_raw(raw_r),
        .o_led_stable(st_z), .o_led_act(act_z), .o_led_valid(vld_z), .o_all_valid(allv_z)
    );

    function automatic logic [12:0] obs(int d);
        case (d)
            0:       return {allv_m, vld_m, act_m, st_m};
            1:       return {allv_r, vld_r, act_r, st_r};
            default: return {allv_z, vld_z, act_z, st_z};
        endcase
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) sb.push_back('{cyc, d, 4'b0, 4'b0, 4'b0, "reset"});
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
    endtask

    task automatic test_startup();
        int base;
        logic [3:0] v, s;
        rst_n = 1'b1;
        base  = cyc;
        for (int k = 1; k <= 19; k++) begin
            v = ((k >= 16) ? ~raw_m : 4'b0) | ((k >= 19) ? raw_m : 4'b0);
            s = (k >= 19) ? raw_m : 4'b0;
            sb.push_back('{base + k, 0, s, 4'b0, v, "startup_m"});
            if (k == 15 || k == 16) begin
                v = (k == 16) ? 4'hF : 4'h0;
                sb.push_back('{base + k, 1, 4'b0, 4'b0, v, "startup_r"});
                sb.push_back('{base + k, 2, 4'b0, 4'b0, v, "startup_z"});
            end
        end
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
    endtask

    task automatic test_change();
        int n;
        @(negedge clk);
        raw_m[0] = 1'b0;
        n = cyc + 1;
        sb.push_back('{n + 16,        0, 4'b0101, 4'b0000, 4'hF, "change_before"});
        sb.push_back('{n + 17,        0, 4'b0100, 4'b0001, 4'hF, "change_commit"});
        sb.push_back('{n + 17 + 3276, 0, 4'b0100, 4'b0001, 4'hF, "act_last"});
        sb.push_back('{n + 17 + 3277, 0, 4'b0100, 4'b0000, 4'hF, "act_expired"});
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
    endtask

    task automatic test_glitch();
        int n, p;
        @(negedge clk);
        n = cyc + 1;
        for (int k = 0; k <= 22; k++) sb.push_back('{n + k, 0, 4'b0100, 4'b0000, 4'hF, "glitch15"});
        fork
            begin
                raw_m[1] = 1'b1;
                repeat (15) @(negedge clk);
                raw_m[1] = 1'b0;
            end
            while (sb.size() != 0) begin
                it = sb.pop_front();
                while (cyc < it.at) @(negedge clk);
                got  = obs(it.dut);
                want = {&it.vld, it.vld, it.act, it.st};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
                end
            end
        join
        @(negedge clk);
        p = cyc + 1;
        // A 16-edge pulse is accepted, and so is the return to 0 that follows it.
        sb.push_back('{p + 16,        0, 4'b0100, 4'b0000, 4'hF, "pulse16_before"});
        sb.push_back('{p + 17,        0, 4'b0110, 4'b0010, 4'hF, "pulse16_rise"});
        sb.push_back('{p + 32,        0, 4'b0110, 4'b0010, 4'hF, "pulse16_hold"});
        sb.push_back('{p + 33,        0, 4'b0100, 4'b0010, 4'hF, "pulse16_fall"});
        sb.push_back('{p + 33 + 3277, 0, 4'b0100, 4'b0000, 4'hF, "pulse16_quiet"});
        fork
            begin
                raw_m[1] = 1'b1;
                repeat (16) @(negedge clk);
                raw_m[1] = 1'b0;
            end
            while (sb.size() != 0) begin
                it = sb.pop_front();
                while (cyc < it.at) @(negedge clk);
                got  = obs(it.dut);
                want = {&it.vld, it.vld, it.act, it.st};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
                end
            end
        join
    endtask

    task automatic test_retrigger();
        int n;
        logic [3:0] s, a;
        @(negedge clk);
        n = cyc + 1;
        for (int k = n + 16; k <= n + 177; k++) begin
            s = (k >= n + 17 && k < n + 77) ? 4'b0100 : 4'b0000;
            a = (k >= n + 17 && k <= n + 176) ? 4'b0100 : 4'b0000;
            sb.push_back('{k, 1, s, a, 4'hF, "retrigger"});
            if (k == n + 17 || k == n + 77 || k == n + 177)
                sb.push_back('{k, 2, s, 4'b0000, 4'hF, "act_disabled"});
        end
        fork
            begin
                raw_r[2] = 1'b1;
                repeat (60) @(negedge clk);
                raw_r[2] = 1'b0;
            end
            while (sb.size() != 0) begin
                it = sb.pop_front();
                while (cyc < it.at) @(negedge clk);
                got  = obs(it.dut);
                want = {&it.vld, it.vld, it.act, it.st};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
                end
            end
        join
    endtask

    task automatic test_simultaneous();
        int n;
        @(negedge clk);
        raw_m = 4'b1011;
        n = cyc + 1;
        sb.push_back('{n + 16, 0, 4'b0100, 4'b0000, 4'hF, "simul_before"});
        sb.push_back('{n + 17, 0, 4'b1011, 4'b1111, 4'hF, "simul_commit"});
        sb.push_back('{n + 18, 0, 4'b1011, 4'b1111, 4'hF, "simul_hold"});
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int m, base;
        logic [3:0] v, s;
        @(negedge clk);
        m = cyc + 1;
        // Commit at m+17 loads 100; reverse edge puts ch2 in PEND from m+62; act_cnt is 50 at m+67.
        sb.push_back('{m + 17, 1, 4'b0100, 4'b0100, 4'hF, "mid_commit"});
        sb.push_back('{m + 67, 1, 4'b0100, 4'b0100, 4'hF, "mid_pend"});
        fork
            begin
                raw_r[2] = 1'b1;
                repeat (60) @(negedge clk);
                raw_r[2] = 1'b0;
            end
            while (sb.size() != 0) begin
                it = sb.pop_front();
                while (cyc < it.at) @(negedge clk);
                got  = obs(it.dut);
                want = {&it.vld, it.vld, it.act, it.st};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
                end
            end
        join
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) sb.push_back('{cyc, d, 4'b0, 4'b0, 4'b0, "async_reset"});
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        for (int k = 1; k <= 25; k++) begin
            v = ((k >= 16) ? ~raw_m : 4'b0) | ((k >= 19) ? raw_m : 4'b0);
            s = (k >= 19) ? raw_m : 4'b0;
            sb.push_back('{base + k, 0, s, 4'b0, v, "requal_m"});
            sb.push_back('{base + k, 1, 4'b0, 4'b0, (k >= 16) ? 4'hF : 4'h0, "requal_r"});
        end
        while (sb.size() != 0) begin
            it = sb.pop_front();
            while (cyc < it.at) @(negedge clk);
            got  = obs(it.dut);
            want = {&it.vld, it.vld, it.act, it.st};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got all/vld/act/st=%b want %b", it.tag, it.dut, it.at, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_change();
        test_glitch();
        test_retrigger();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: cycle %0d reached, bench did not complete", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/t5_led_cond.md
Name: t5_led_cond

Overview:
- Per-channel input conditioner for raw PHY LED pins, sitting directly upstream of the T5 LED speed decoder.
- Synchronises each raw LED line into the 32 kHz domain and rejects glitches with a consecutive-sample debounce.
- Produces clean levels for the downstream speed decode.
- Also produces a stretched activity flag for every qualified level change, plus per-channel valid flags that hold off downstream decode until startup qualification completes.

Parameters:
- NUM_CH, 4: number of LED channels (LED1_1, LED1_3, LED2_1, LED2_3).
- DEB_CYC, 16: consecutive differing samples needed to accept a new level; legal range 2..255 (16 cycles ≈ 0.5 ms).
- ACT_HOLD, 3277: cycles o_led_act stays high after a qualified change (≈100 ms); 0 disables activity.
- ACT_W, 12: activity counter width; must satisfy ACT_HOLD < 2^ACT_W.

Ports:
- i_clk_32k, in, 1: 32.768 kHz system clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_led_raw, in, NUM_CH: raw asynchronous PHY LED pins.
- o_led_stable, out, NUM_CH: debounced level per channel.
- o_led_act, out, NUM_CH: stretched activity flag per channel.
- o_led_valid, out, NUM_CH: channel has completed startup qualification.
- o_all_valid, out, 1: AND of o_led_valid.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - Sync flops r1, r2, r3 = 0, debounce count = 0, activity count = 0, state = INIT.
  - All outputs = 0.
  - Reset asserted mid-operation aborts everything and restarts in INIT. No activity pulse is produced on reset exit.
- Sync chain per channel, every edge: r1 <= raw, r2 <= r1, r3 <= r2. r3 is used only in INIT.
- Per-channel FSM with states INIT, STABLE, PEND:
  - INIT:
    - If r2 != r3: count <= 0.
    - Else if count == DEB_CYC-1: stable <= r2, valid <= 1, count <= 0, go to STABLE. No activity load.
    - Else: count++.
  - STABLE:
    - If r2 != stable: count <= 1, go to PEND.
    - Otherwise: hold, count = 0.
  - PEND:
    - If r2 == stable: count <= 0, go to STABLE (glitch rejected, no output change).
    - Else if count == DEB_CYC-1: stable <= r2, count <= 0, act_cnt <= ACT_HOLD, go to STABLE.
    - Else: count++.
- Acceptance rule and latency:
  - A new level is accepted if and only if raw differs from stable for exactly DEB_CYC or more consecutive sampling edges.
  - If raw changes before edge 0, o_led_stable updates at edge DEB_CYC+1.
  - A run of DEB_CYC-1 differing samples leaves the output unchanged.
- Activity:
  - o_led_act = (act_cnt != 0). act_cnt decrements each edge while nonzero, and saturates at 0.
  - A qualified change while act_cnt != 0 reloads ACT_HOLD (retrigger extends the pulse). Load has priority over decrement in the same cycle.
  - With ACT_HOLD = 0, o_led_act stays 0.
- Startup timing with DEB_CYC = 16, edges counted from the first edge after reset release = e1:
  - Constant raw = 0: valid and stable = 0 at e16.
  - Constant raw = 1: mismatch at e3, then valid and stable = 1 at e19.
- Once set, o_led_valid stays high until reset.
- Channels are fully independent. Simultaneous changes on several channels are each handled in their own FSM.
- All outputs are registered. There is no combinational path from i_led_raw to any output.

Decomposition:
- Package t5_led_pkg holds:
  - State encoding constants ST_INIT = 2'd0, ST_STABLE = 2'd1, ST_PEND = 2'd2.
  - Default constants for DEB_CYC, ACT_HOLD and ACT_W.
- Sub-module t5_led_cond_ch contains one channel: sync chain, FSM, debounce counter and activity counter. It is instantiated NUM_CH times via generate.
- The top level adds only the o_all_valid reduction.

Test Plan:
1. Startup, constant levels: raw = 4'b0101 from reset → o_led_stable = 4'b0101 and o_all_valid = 1 by e19; o_led_act = 0 throughout.
2. Qualified change: after valid, ch0 raw 1→0 held, first sampled at edge n → o_led_stable[0] = 0 at n+17; o_led_act[0] = 1 for exactly 3277 cycles.
3. Glitch rejection: ch1 raw pulses 0→1 for exactly 15 sampling edges → o_led_stable[1] and o_led_act[1] never change. The same pulse at 16 edges is accepted.
4. Retrigger: ACT_HOLD = 100; two qualified toggles on ch2 spaced 60 cycles apart → o_led_act[2] high continuously for 160 cycles after the first commit.
5. Reset mid-operation: assert i_rst_n low during PEND with act_cnt = 50 → all outputs 0 immediately (asynchronously); after release the channel re-qualifies per scenario 1 with no activity pulse.
6. Simultaneous channels: all four raw lines toggle on the same edge → all four o_led_stable bits update on the same edge (n+17), and all four o_led_act bits assert together.
